// File: rtl/seg_scan_driver.sv
// ============================================================================
// Module   : seg_scan_driver
// Purpose  : Time-multiplexed driver for a 4-digit common-anode seven-segment
//            display. Requests one digit at a time from a combinational symbol
//            source and samples the returned code. Decodes it to active-low
//            segments and strobes the matching anode for the rest of the slot.
//
// Parameters
//   REFRESH_DIV : clock cycles per digit slot (2 .. 2^20); one slot is
//                 1 SETTLE cycle followed by REFRESH_DIV-1 DRIVE cycles
//   BLANK_CYC   : anode-off cycles at the start of DRIVE (< REFRESH_DIV-1);
//                 only has an effect when GHOST_BLANK_EN is defined
//
// Build option
//   GHOST_BLANK_EN : when defined, the anode is held off for the first
//                    BLANK_CYC cycles of each DRIVE phase
//
// Ports
//   clk        in   1  system clock, rising edge
//   rst_n      in   1  asynchronous active-low reset
//   en         in   1  display enable; low blanks the display
//   sym_in     in   4  symbol code for the current digit_sel
//   dp_mask    in   4  decimal-point enable per digit, bit k = digit k
//   digit_sel  out  2  digit requested from the source; 3 = leftmost
//   an_n       out  4  anode enables, active-low, bit k = digit k
//   seg_n      out  7  segments {g,f,e,d,c,b,a}, active-low
//   dp_n       out  1  decimal point, active-low
//   frame_tick out  1  one-cycle pulse after digit 3 finishes its slot
//
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan_driver #(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned BLANK_CYC   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] sym_in,
    input  logic [3:0] dp_mask,
    output logic [1:0] digit_sel,
    output logic [3:0] an_n,
    output logic [6:0] seg_n,
    output logic       dp_n,
    output logic       frame_tick
);

    localparam int unsigned c_DIV_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(REFRESH_DIV - 2);
    localparam logic [6:0] c_SEG_OFF = 7'b1111111;
    localparam logic [3:0] c_AN_OFF  = 4'b1111;

`ifdef GHOST_BLANK_EN
    localparam int unsigned c_BLANK = BLANK_CYC;
`else
    // BLANK_CYC is accepted but has no effect in this build.
    localparam int unsigned c_BLANK = 0 * BLANK_CYC;
`endif
    // Divider value of the last dark DRIVE cycle; the anode turns on at the
    // following edge. Only meaningful when c_BLANK is non-zero.
    localparam logic [c_DIV_W-1:0] c_BLANK_LAST =
        (c_BLANK == 0) ? '0 : c_DIV_W'(c_BLANK - 1);

    typedef enum logic [1:0] {
        S_OFF    = 2'd0,
        S_SETTLE = 2'd1,
        S_DRIVE  = 2'd2
    } state_t;

    state_t             state_q,      state_d;
    logic [1:0]         digit_sel_q,  digit_sel_d;
    logic [c_DIV_W-1:0] div_q,        div_d;
    logic [3:0]         an_n_q,       an_n_d;
    logic [6:0]         seg_n_q,      seg_n_d;
    logic               dp_n_q,       dp_n_d;
    logic               frame_tick_q, frame_tick_d;

    logic [6:0]         w_seg;
    logic [3:0]         w_an_sel;

    // Symbol decode, {g,f,e,d,c,b,a} active-low.
    always_comb begin
        w_seg = c_SEG_OFF;
        case (sym_in)
            4'h0:    w_seg = 7'b1000000;
            4'h1:    w_seg = 7'b1111001;
            4'h2:    w_seg = 7'b0100100;
            4'h3:    w_seg = 7'b0110000;
            4'h4:    w_seg = 7'b0011001;
            4'h5:    w_seg = 7'b0010010;
            4'h6:    w_seg = 7'b0000010;
            4'h7:    w_seg = 7'b1111000;
            4'h8:    w_seg = 7'b0000000;
            4'h9:    w_seg = 7'b0010000;
            4'hB:    w_seg = 7'b0111111;   // '-'
            4'hC:    w_seg = 7'b0000110;   // 'E'
            4'hD:    w_seg = 7'b0101111;   // 'r'
            default: w_seg = c_SEG_OFF;    // A, E, F render blank
        endcase
    end

    assign w_an_sel = ~(4'b0001 << digit_sel_q);

    always_comb begin
        state_d      = state_q;
        digit_sel_d  = digit_sel_q;
        div_d        = div_q;
        an_n_d       = an_n_q;
        seg_n_d      = seg_n_q;
        dp_n_d       = dp_n_q;
        frame_tick_d = 1'b0;

        if (!en) begin
            // Abandon the scan immediately; no partial slot, no tick.
            state_d     = S_OFF;
            digit_sel_d = 2'd0;
            div_d       = '0;
            an_n_d      = c_AN_OFF;
            seg_n_d     = c_SEG_OFF;
            dp_n_d      = 1'b1;
        end else begin
            case (state_q)
                S_OFF: begin
                    state_d     = S_SETTLE;
                    digit_sel_d = 2'd0;
                    div_d       = '0;
                end
                S_SETTLE: begin
                    // The source has had a full cycle to answer digit_sel.
                    seg_n_d = w_seg;
                    dp_n_d  = ~dp_mask[digit_sel_q];
                    an_n_d  = (c_BLANK == 0) ? w_an_sel : c_AN_OFF;
                    div_d   = '0;
                    state_d = S_DRIVE;
                end
                S_DRIVE: begin
                    if (div_q == c_DIV_LAST) begin
                        // Go dark before the source is asked for the next digit.
                        digit_sel_d  = digit_sel_q + 2'd1;
                        an_n_d       = c_AN_OFF;
                        seg_n_d      = c_SEG_OFF;
                        dp_n_d       = 1'b1;
                        div_d        = '0;
                        state_d      = S_SETTLE;
                        frame_tick_d = (digit_sel_q == 2'd3);
                    end else begin
                        div_d = div_q + c_DIV_W'(1);
                        if ((c_BLANK != 0) && (div_q == c_BLANK_LAST)) begin
                            an_n_d = w_an_sel;
                        end
                    end
                end
                default: begin
                    state_d = S_OFF;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_OFF;
            digit_sel_q  <= 2'd0;
            div_q        <= '0;
            an_n_q       <= c_AN_OFF;
            seg_n_q      <= c_SEG_OFF;
            dp_n_q       <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            digit_sel_q  <= digit_sel_d;
            div_q        <= div_d;
            an_n_q       <= an_n_d;
            seg_n_q      <= seg_n_d;
            dp_n_q       <= dp_n_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign digit_sel  = digit_sel_q;
    assign an_n       = an_n_q;
    assign seg_n      = seg_n_q;
    assign dp_n       = dp_n_q;
    assign frame_tick = frame_tick_q;

endmodule

`default_nettype wire

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Time-multiplexed driver for the 4-digit common-anode seven-segment display. It is the consumer end of the digit-select/symbol interface used by the display symbol sources (count digits, error-message muxes). The block drives the 2-bit digit select outward and samples the returned 4-bit symbol code. It then decodes the code to active-low segments and strobes one anode per slot. It sits between the stopwatch datapath/symbol muxes and the board pins.

Parameters:
REFRESH_DIV, 50000, clock cycles per digit slot; legal range 2..2^20; slot = 1 SETTLE + (REFRESH_DIV-1) DRIVE cycles
BLANK_CYC, 16, anode-off cycles at the start of each DRIVE phase; used only with GHOST_BLANK_EN; must be < REFRESH_DIV-1

Ports:
clk        in   1  system clock, rising edge
rst_n      in   1  asynchronous active-low reset
en         in   1  display enable; low blanks the display
sym_in     in   4  symbol code returned by the source for the current digit_sel (combinational at the source)
dp_mask    in   4  decimal-point enable per digit, bit k = digit k
digit_sel  out  2  digit currently requested from the symbol source; 3 = leftmost
an_n       out  4  anode enables, active-low, bit k = digit k
seg_n      out  7  segments {g,f,e,d,c,b,a}, active-low
dp_n       out  1  decimal point, active-low
frame_tick out  1  one-cycle pulse when digit 3 finishes its slot (wrap to 0)

Behaviour:
- Reset (async assert, sync release): state=OFF, digit_sel=0, an_n=4'b1111, seg_n=7'b1111111, dp_n=1, frame_tick=0, divider=0.
- All outputs are registered. The divider is ceil(log2(REFRESH_DIV)) bits wide.
- FSM states: OFF, SETTLE, DRIVE.
- OFF: all outputs held at reset values.
  - en=1 -> SETTLE with digit_sel=0.
- SETTLE (exactly 1 cycle): the source has one full cycle to respond to digit_sel. At the end of the cycle:
  - latch sym_in and dp_mask[digit_sel];
  - load seg_n/dp_n from the decode;
  - drive an_n bit digit_sel low;
  - go to DRIVE with divider=0.
- DRIVE: divider increments each cycle. an_n, seg_n and dp_n are frozen; sym_in changes are ignored. When divider = REFRESH_DIV-2:
  - digit_sel <= digit_sel+1 (wraps 3->0);
  - an_n <= 4'b1111 and seg_n <= all-off, so the display is dark during the next SETTLE;
  - go to SETTLE;
  - if digit_sel was 3, frame_tick=1 for that cycle.
- en deasserted in any state -> OFF on the next edge. Outputs return to reset values and digit_sel=0. No partial slot is completed and frame_tick is not pulsed.
- en re-asserted while in OFF restarts at digit 0; scan phase does not resume from where it stopped.
- Decode table (sym_in -> seg_n):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - B '-'=0111111
  - C 'E'=0000110
  - D 'r'=0101111
  - A, E, F: blank = 1111111
- Exactly one an_n bit is low in DRIVE; none are low in OFF or SETTLE.
- Full frame = 4*REFRESH_DIV cycles.

Optional Feature:
GHOST_BLANK_EN
- Defined: an_n stays 4'b1111 for the first BLANK_CYC cycles of DRIVE, then asserts the selected digit for the remainder of the slot. seg_n/dp_n are loaded at SETTLE as normal. This suppresses ghosting on slow anode drivers. Slot length is unchanged.
- Undefined: an_n asserts immediately at DRIVE entry and BLANK_CYC is ignored.

Test Plan:
- Reset: assert rst_n=0 mid-DRIVE -> same cycle an_n=1111, seg_n=1111111, dp_n=1, digit_sel=0, frame_tick=0.
- Scan order (REFRESH_DIV=4, en=1, source returns {3:'-'(B), 2:'E'(C), 1:0, 0:1}):
  - digit_sel sequence 0,1,2,3,0 every 4 cycles;
  - an_n 1110, 1101, 1011, 0111, with one dark cycle between each;
  - seg_n 1111001, 1000000, 0000110, 0111111;
  - frame_tick pulses once every 16 cycles.
- Sym hold: change sym_in during DRIVE of digit 1 -> seg_n unchanged until the next SETTLE for digit 1.
- Decimal point: dp_mask=4'b0100 -> dp_n=0 only while an_n=1011.
- Enable drop: en=0 during digit 2 DRIVE -> next edge all outputs off with no frame_tick. en=1 again -> scan restarts at digit_sel=0.
- Blank codes: sym_in=A/E/F -> seg_n=1111111 with the anode still asserted. With GHOST_BLANK_EN, BLANK_CYC=1, REFRESH_DIV=6 -> an_n low for 4 of every 6 cycles.
